// File: rtl/inst_encoder_pkg.sv
// Shared types for the instruction encoder: format and state enums, error codes,
// and the mapping from a failing format to its error code.
package inst_encoder_pkg;

    typedef enum logic [1:0] {
        FMT_I = 2'd0,
        FMT_S = 2'd1,
        FMT_B = 2'd2,
        FMT_R = 2'd3
    } fmt_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_FULL = 2'd2
    } state_e;

    localparam logic [1:0] ERR_NONE     = 2'd0;
    localparam logic [1:0] ERR_IS_RANGE = 2'd1;
    localparam logic [1:0] ERR_B_RANGE  = 2'd2;

    function automatic logic [1:0] err_code_for(input fmt_e fmt);
        return (fmt == FMT_B) ? ERR_B_RANGE : ERR_IS_RANGE;
    endfunction

endpackage

// File: rtl/inst_encoder_if.sv
// Request/write bus of the instruction encoder; the encoder uses the slave view,
// the request source and memory side use the master view.
interface inst_encoder_if;

    logic        start;
    logic        in_valid;
    logic        in_ready;
    logic [1:0]  in_fmt;
    logic [6:0]  in_opcode;
    logic [4:0]  in_rd;
    logic [4:0]  in_rs1;
    logic [4:0]  in_rs2;
    logic [2:0]  in_funct3;
    logic [6:0]  in_funct7;
    logic [63:0] in_imm;
    logic        out_we;
    logic [63:0] out_addr;
    logic [31:0] out_inst;
    logic        full;
    logic        err;
    logic [1:0]  err_code;

    modport slave (
        input  start, in_valid, in_fmt, in_opcode, in_rd, in_rs1, in_rs2,
               in_funct3, in_funct7, in_imm,
        output in_ready, out_we, out_addr, out_inst, full, err, err_code
    );

    modport master (
        output start, in_valid, in_fmt, in_opcode, in_rd, in_rs1, in_rs2,
               in_funct3, in_funct7, in_imm,
        input  in_ready, out_we, out_addr, out_inst, full, err, err_code
    );

endinterface

// File: rtl/inst_encoder_pack.sv
// Combinational packer: assembles an I/S/B/R instruction word from its fields and
// flags immediates that do not fit the selected format.
module inst_pack
    import inst_encoder_pkg::*;
(
    input  fmt_e        i_fmt,
    input  logic [6:0]  i_opcode,
    input  logic [4:0]  i_rd,
    input  logic [4:0]  i_rs1,
    input  logic [4:0]  i_rs2,
    input  logic [2:0]  i_funct3,
    input  logic [6:0]  i_funct7,
    input  logic [63:0] i_imm,
    output logic [31:0] o_inst,
    output logic        o_range_err
);

    logic w_fits_12;
    logic w_fits_13;

    // A value fits N signed bits when everything from bit N-1 upward is a copy of the sign.
    assign w_fits_12 = (&i_imm[63:11]) | ~(|i_imm[63:11]);
    assign w_fits_13 = (&i_imm[63:12]) | ~(|i_imm[63:12]);

    // Field placement and range check per format.
    always_comb begin
        o_inst      = 32'h0000_0000;
        o_range_err = 1'b0;
        case (i_fmt)
            FMT_I: begin
                o_inst      = {i_imm[11:0], i_rs1, i_funct3, i_rd, i_opcode};
                o_range_err = ~w_fits_12;
            end
            FMT_S: begin
                o_inst      = {i_imm[11:5], i_rs2, i_rs1, i_funct3, i_imm[4:0], i_opcode};
                o_range_err = ~w_fits_12;
            end
            FMT_B: begin
                o_inst      = {i_imm[12], i_imm[10:5], i_rs2, i_rs1, i_funct3,
                               i_imm[4:1], i_imm[11], i_opcode};
                o_range_err = ~w_fits_13 | i_imm[0];
            end
            FMT_R: begin
                o_inst      = {i_funct7, i_rs2, i_rs1, i_funct3, i_rd, i_opcode};
                o_range_err = 1'b0;
            end
            default: begin
                o_inst      = 32'h0000_0000;
                o_range_err = 1'b0;
            end
        endcase
    end

endmodule

// File: rtl/inst_encoder.sv
// Instruction encoder top: session FSM, word counter, address generator and the
// registered write port towards instruction memory.
module inst_encoder
    import inst_encoder_pkg::*;
#(
    parameter int unsigned MEM_WORDS = 256,
    parameter logic [63:0] BASE_ADDR = 64'h0
)(
    input  logic          clk,
    input  logic          rst_n,
    inst_encoder_if.slave bus
);

    localparam int unsigned CNT_W = $clog2(MEM_WORDS + 1);
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(MEM_WORDS - 1);

    state_e             r_state;
    state_e             w_state_nxt;
    logic [CNT_W-1:0]   r_count;
    logic [63:0]        r_next_addr;
    logic               r_we;
    logic [63:0]        r_addr;
    logic [31:0]        r_inst;
    logic               r_err;
    logic [1:0]         r_err_code;
    logic               r_in_ready;
    logic               r_full;

    logic               w_restart;
    logic               w_write;
    logic               w_reject;
    logic [31:0]        w_inst;
    logic               w_range_err;
    fmt_e               w_fmt;

    assign w_fmt = fmt_e'(bus.in_fmt);

    inst_pack u_pack (
        .i_fmt       (w_fmt),
        .i_opcode    (bus.in_opcode),
        .i_rd        (bus.in_rd),
        .i_rs1       (bus.in_rs1),
        .i_rs2       (bus.in_rs2),
        .i_funct3    (bus.in_funct3),
        .i_funct7    (bus.in_funct7),
        .i_imm       (bus.in_imm),
        .o_inst      (w_inst),
        .o_range_err (w_range_err)
    );

    // Session state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next state and per-cycle actions; start always wins over a same-cycle request.
    always_comb begin
        w_state_nxt = r_state;
        w_restart   = 1'b0;
        w_write     = 1'b0;
        w_reject    = 1'b0;
        case (r_state)
            ST_IDLE, ST_FULL: begin
                if (bus.start) begin
                    w_restart   = 1'b1;
                    w_state_nxt = ST_RUN;
                end else begin
                    w_state_nxt = r_state;
                end
            end
            ST_RUN: begin
                if (bus.start) begin
                    w_restart   = 1'b1;
                    w_state_nxt = ST_RUN;
                end else if (bus.in_valid && r_in_ready) begin
                    if (w_range_err) begin
                        w_reject = 1'b1;
                    end else begin
                        w_write = 1'b1;
                        if (r_count == LAST_CNT) begin
                            w_state_nxt = ST_FULL;
                        end else begin
                            w_state_nxt = ST_RUN;
                        end
                    end
                end else begin
                    w_state_nxt = ST_RUN;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    // Write port, counters and error flags.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_count     <= '0;
            r_next_addr <= BASE_ADDR;
            r_we        <= 1'b0;
            r_addr      <= BASE_ADDR;
            r_inst      <= 32'h0000_0000;
            r_err       <= 1'b0;
            r_err_code  <= ERR_NONE;
            r_in_ready  <= 1'b0;
            r_full      <= 1'b0;
        end else begin
            r_we       <= w_write;
            r_in_ready <= (w_state_nxt == ST_RUN);
            r_full     <= (w_state_nxt == ST_FULL);
            if (w_restart) begin
                r_count     <= '0;
                r_next_addr <= BASE_ADDR;
                r_err       <= 1'b0;
                r_err_code  <= ERR_NONE;
            end else if (w_write) begin
                r_inst      <= w_inst;
                r_addr      <= r_next_addr;
                r_next_addr <= r_next_addr + 64'd4;
                r_count     <= r_count + CNT_W'(1);
            end else if (w_reject) begin
                r_err      <= 1'b1;
                r_err_code <= err_code_for(w_fmt);
            end
        end
    end

    assign bus.in_ready = r_in_ready;
    assign bus.out_we   = r_we;
    assign bus.out_addr = r_addr;
    assign bus.out_inst = r_inst;
    assign bus.full     = r_full;
    assign bus.err      = r_err;
    assign bus.err_code = r_err_code;

endmodule

// File: tb/tb_inst_encoder.sv
// Directed bench for inst_encoder with a behavioural reference model and
// hand-computed literal checks on the key encodings and boundaries.
module tb_inst_encoder;

    localparam int unsigned MW   = 4;
    localparam logic [63:0] BASE = 64'h0000_0000_8000_0000;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   n_cmp = 0;
    int   n_bad = 0;

    inst_encoder_if bus ();

    inst_encoder #(.MEM_WORDS(MW), .BASE_ADDR(BASE)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference encoding built from arithmetic shifts of the field values.
    function automatic logic [31:0] model_word(input int fmt, input longint unsigned op,
            input longint unsigned rd, input longint unsigned rs1, input longint unsigned rs2,
            input longint unsigned f3, input longint unsigned f7, input longint unsigned imm);
        longint unsigned v;
        v = (rs1 << 15) | (f3 << 12) | op;
        case (fmt)
            0: v = v | ((imm & 64'hFFF) << 20) | (rd << 7);
            1: v = v | (((imm >> 5) & 64'h7F) << 25) | (rs2 << 20) | ((imm & 64'h1F) << 7);
            2: v = v | (((imm >> 12) & 64'h1) << 31) | (((imm >> 5) & 64'h3F) << 25) | (rs2 << 20)
                     | (((imm >> 1) & 64'hF) << 8) | (((imm >> 11) & 64'h1) << 7);
            default: v = v | (f7 << 25) | (rs2 << 20) | (rd << 7);
        endcase
        return v[31:0];
    endfunction

    function automatic bit model_bad(input int fmt, input logic [63:0] imm);
        longint s;
        s = $signed(imm);
        if (fmt == 0 || fmt == 1) return (s < -2048) || (s > 2047);
        if (fmt == 2) return (s < -4096) || (s > 4095) || (s % 2 != 0);
        return 1'b0;
    endfunction

    bit          m_running = 1'b0;
    bit          m_full    = 1'b0;
    int          m_count   = 0;
    logic [63:0] m_next    = BASE;
    bit          m_we      = 1'b0;
    logic [31:0] m_inst    = 32'h0;
    logic [63:0] m_addr    = BASE;
    bit          m_err     = 1'b0;
    logic [1:0]  m_code    = 2'd0;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_running = 1'b0; m_full = 1'b0; m_count = 0; m_next = BASE;
            m_we = 1'b0; m_inst = 32'h0; m_addr = BASE; m_err = 1'b0; m_code = 2'd0;
        end else begin
            m_we = 1'b0;
            if (bus.start) begin
                m_running = 1'b1; m_full = 1'b0; m_count = 0; m_next = BASE;
                m_err = 1'b0; m_code = 2'd0;
            end else if (m_running && !m_full && bus.in_valid) begin
                if (model_bad(int'(bus.in_fmt), bus.in_imm)) begin
                    m_err = 1'b1;
                    m_code = (bus.in_fmt == 2'd2) ? 2'd2 : 2'd1;
                end else begin
                    m_we = 1'b1;
                    m_inst = model_word(int'(bus.in_fmt), 64'(bus.in_opcode), 64'(bus.in_rd),
                        64'(bus.in_rs1), 64'(bus.in_rs2), 64'(bus.in_funct3), 64'(bus.in_funct7), bus.in_imm);
                    m_addr = m_next;
                    m_next = m_next + 64'd4;
                    m_count++;
                    if (m_count == MW) m_full = 1'b1;
                end
            end
        end
    end

    // Every-cycle comparison of all outputs against the model.
    always @(negedge clk) begin
        chk("out_we",   64'(bus.out_we),   64'(m_we));
        chk("out_inst", 64'(bus.out_inst), 64'(m_inst));
        chk("out_addr", bus.out_addr,      m_addr);
        chk("in_ready", 64'(bus.in_ready), 64'(m_running && !m_full));
        chk("full",     64'(bus.full),     64'(m_full));
        chk("err",      64'(bus.err),      64'(m_err));
        chk("err_code", 64'(bus.err_code), 64'(m_code));
    end

    task automatic req(input logic [1:0] fmt, input logic [6:0] op, input logic [4:0] rd,
            input logic [4:0] rs1, input logic [4:0] rs2, input logic [2:0] f3,
            input logic [6:0] f7, input logic [63:0] imm);
        bus.in_valid = 1'b1; bus.in_fmt = fmt; bus.in_opcode = op; bus.in_rd = rd;
        bus.in_rs1 = rs1; bus.in_rs2 = rs2; bus.in_funct3 = f3; bus.in_funct7 = f7; bus.in_imm = imm;
        @(negedge clk);
        bus.in_valid = 1'b0;
    endtask

    task automatic pulse_start();
        bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) @(negedge clk);
    endtask

    task automatic chk_reset_values(input string tag);
        chk({tag, "_we"},    64'(bus.out_we),   64'd0);
        chk({tag, "_inst"},  64'(bus.out_inst), 64'd0);
        chk({tag, "_addr"},  bus.out_addr,      BASE);
        chk({tag, "_full"},  64'(bus.full),     64'd0);
        chk({tag, "_err"},   64'(bus.err),      64'd0);
        chk({tag, "_code"},  64'(bus.err_code), 64'd0);
        chk({tag, "_ready"}, 64'(bus.in_ready), 64'd0);
    endtask

    initial begin
        bus.start = 1'b0; bus.in_valid = 1'b0; bus.in_fmt = 2'd0; bus.in_opcode = 7'd0;
        bus.in_rd = 5'd0; bus.in_rs1 = 5'd0; bus.in_rs2 = 5'd0; bus.in_funct3 = 3'd0;
        bus.in_funct7 = 7'd0; bus.in_imm = 64'd0;
        idle(3);
        chk_reset_values("por");
        rst_n = 1'b1;
        idle(1);
        req(2'd3, 7'h33, 5'd1, 5'd1, 5'd1, 3'd0, 7'd0, 64'd0);
        chk("idle_no_we", 64'(bus.out_we), 64'd0);
        pulse_start();
        chk("run_ready", 64'(bus.in_ready), 64'd1);

        req(2'd0, 7'b0000011, 5'd5, 5'd2, 5'd0, 3'd3, 7'd0, -64'sd8);
        chk("i_we", 64'(bus.out_we), 64'd1);
        chk("i_inst", 64'(bus.out_inst), 64'hFF81_3283);
        chk("i_addr", bus.out_addr, BASE);
        req(2'd1, 7'b0100011, 5'd0, 5'd2, 5'd6, 3'd3, 7'd0, 64'd16);
        chk("s_inst", 64'(bus.out_inst), 64'h0061_3823);
        chk("s_addr", bus.out_addr, BASE + 64'd4);
        req(2'd0, 7'b0000011, 5'd5, 5'd2, 5'd0, 3'd3, 7'd0, 64'd2048);
        chk("irange_we", 64'(bus.out_we), 64'd0);
        chk("irange_err", 64'(bus.err), 64'd1);
        chk("irange_code", 64'(bus.err_code), 64'd1);
        req(2'd2, 7'b1100011, 5'd0, 5'd1, 5'd2, 3'd0, 7'd0, -64'sd4);
        chk("b_inst", 64'(bus.out_inst), 64'hFE20_8EE3);
        chk("b_addr", bus.out_addr, BASE + 64'd8);
        chk("err_sticky", 64'(bus.err), 64'd1);
        req(2'd2, 7'b1100011, 5'd0, 5'd1, 5'd2, 3'd0, 7'd0, 64'd3);
        chk("bmis_we", 64'(bus.out_we), 64'd0);
        chk("bmis_code", 64'(bus.err_code), 64'd2);
        req(2'd3, 7'h33, 5'd5, 5'd4, 5'd3, 3'd0, 7'h20, 64'hDEAD_BEEF_0000_0001);
        chk("r_inst", 64'(bus.out_inst), 64'h4032_02B3);
        chk("r_addr", bus.out_addr, BASE + 64'd12);
        chk("full_set", 64'(bus.full), 64'd1);
        chk("full_ready", 64'(bus.in_ready), 64'd0);
        req(2'd0, 7'h13, 5'd1, 5'd1, 5'd0, 3'd0, 7'd0, 64'd1);
        req(2'd0, 7'h13, 5'd1, 5'd1, 5'd0, 3'd0, 7'd0, 64'd2);
        chk("full_no_we", 64'(bus.out_we), 64'd0);

        pulse_start();
        chk("restart_ready", 64'(bus.in_ready), 64'd1);
        chk("restart_full", 64'(bus.full), 64'd0);
        chk("restart_err", 64'(bus.err), 64'd0);
        req(2'd0, 7'h13, 5'd7, 5'd8, 5'd0, 3'd0, 7'd0, 64'd2047);
        chk("restart_addr", bus.out_addr, BASE);
        req(2'd0, 7'h13, 5'd7, 5'd8, 5'd0, 3'd0, 7'd0, -64'sd2048);
        bus.start = 1'b1;
        req(2'd3, 7'h33, 5'd9, 5'd9, 5'd9, 3'd7, 7'd0, 64'd0);
        bus.start = 1'b0;
        chk("start_discard", 64'(bus.out_we), 64'd0);
        req(2'd2, 7'h63, 5'd0, 5'd3, 5'd4, 3'd1, 7'd0, 64'd4094);
        req(2'd2, 7'h63, 5'd0, 5'd3, 5'd4, 3'd1, 7'd0, -64'sd4096);
        req(2'd2, 7'h63, 5'd0, 5'd3, 5'd4, 3'd1, 7'd0, 64'd4096);
        req(2'd1, 7'h23, 5'd0, 5'd3, 5'd4, 3'd2, 7'd0, -64'sd2049);
        req(2'd1, 7'h23, 5'd0, 5'd3, 5'd4, 3'd2, 7'd0, -64'sd1);
        req(2'd3, 7'h33, 5'd31, 5'd30, 5'd29, 3'd5, 7'h7F, 64'd0);
        idle(2);

        pulse_start();
        req(2'd0, 7'h13, 5'd3, 5'd4, 5'd0, 3'd0, 7'd0, 64'd100);
        bus.in_valid = 1'b1; bus.in_fmt = 2'd3; bus.in_imm = 64'd0;
        @(posedge clk);
        #2 rst_n = 1'b0;
        bus.in_valid = 1'b0;
        #1 chk_reset_values("mid_rst");
        @(negedge clk);
        rst_n = 1'b1;
        req(2'd3, 7'h33, 5'd1, 5'd2, 5'd3, 3'd0, 7'd0, 64'd0);
        chk("post_rst_no_we", 64'(bus.out_we), 64'd0);
        pulse_start();
        req(2'd3, 7'h33, 5'd1, 5'd2, 5'd3, 3'd0, 7'd0, 64'd0);
        chk("post_rst_addr", bus.out_addr, BASE);
        chk("post_rst_we", 64'(bus.out_we), 64'd1);
        idle(3);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/inst_encoder.md
INST_ENCODER -- requirements
Module: inst_encoder

Interface
REQ-001 Parameter MEM_WORDS, default 256: number of instruction words writable before the block reports full.
REQ-002 Parameter BASE_ADDR, default 64'h0: byte address of the first written word.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst_n  input  1  reset, asynchronous, active-low.
REQ-005 start  input  1  one-cycle pulse; (re)starts a load session.
REQ-006 in_valid  input  1  encode request present.
REQ-007 in_ready  output  1  block accepts a request this cycle.
REQ-008 in_fmt  input  2  format: 0=I, 1=S, 2=B, 3=R.
REQ-009 in_opcode  input  7  opcode field.
REQ-010 in_rd, in_rs1, in_rs2  input  5 each  register fields.
REQ-011 in_funct3  input  3  funct3 field.
REQ-012 in_funct7  input  7  funct7 field; used by R only.
REQ-013 in_imm  input  64  sign-extended immediate, byte offset for B.
REQ-014 out_we  output  1  one-cycle write strobe to instruction memory.
REQ-015 out_addr  output  64  byte address of the written word.
REQ-016 out_inst  output  32  encoded instruction word.
REQ-017 full  output  1  MEM_WORDS words written this session.
REQ-018 err  output  1  sticky range-error flag.
REQ-019 err_code  output  2  last error: 0=none, 1=I/S range, 2=B range or misaligned.

Function
REQ-020 FSM states IDLE, RUN, FULL; reset state IDLE.
REQ-021 IDLE: start -> RUN; word counter=0; next address=BASE_ADDR; err and err_code cleared.
REQ-022 RUN: in_ready=1; handshake = in_valid && in_ready.
REQ-023 Not RUN: in_ready=0.
REQ-024 Accepted request -> out_we=1 on the following cycle with registered out_inst and out_addr; latency exactly 1 cycle; throughput 1 per cycle.
REQ-025 I encoding: {imm[11:0], rs1, funct3, rd, opcode}.
REQ-026 S encoding: {imm[11:5], rs2, rs1, funct3, imm[4:0], opcode}.
REQ-027 B encoding: {imm[12], imm[10:5], rs2, rs1, funct3, imm[4:1], imm[11], opcode}.
REQ-028 R encoding: {funct7, rs2, rs1, funct3, rd, opcode}; in_imm ignored; never errors.
REQ-029 I/S range: imm[63:11] all equal; else err_code=1.
REQ-030 B range: imm[63:12] all equal and imm[0]=0; else err_code=2.
REQ-031 Range violation: request consumed; no write (out_we stays 0); address and counter unchanged; err set sticky; err_code updated.
REQ-032 Each write: address +4; counter +1.
REQ-033 Counter reaching MEM_WORDS on a write: FULL, full=1, in_ready=0 from the next cycle.
REQ-034 start in RUN or FULL: restarts the session as in REQ-021 and enters RUN; a request handshaken in the same cycle is discarded.
REQ-035 out_we, out_inst and out_addr not driven by a write: out_we=0; out_inst and out_addr hold their last values.

Reset
REQ-036 rst_n low: immediately forces IDLE, out_we=0, out_inst=0, out_addr=BASE_ADDR, full=0, err=0, err_code=0, counter=0, in_ready=0.
REQ-037 Reset mid-session: pending write is dropped; a new start is required after release.

Structure
REQ-038 Shared package holds the fmt enum (FMT_I, FMT_S, FMT_B, FMT_R), state enum and err_code constants.
REQ-039 Encoding and range check sit in one combinational sub-module inst_pack (inputs fmt, fields, imm; outputs inst, range_err); the top holds the FSM, counter and output registers.

Verification
REQ-040 I: fmt=0, opcode=7'b0000011, f3=3, rd=5, rs1=2, imm=-8 -> out_inst=32'hFF813283 at out_addr=BASE_ADDR, one cycle after handshake.
REQ-041 S: fmt=1, opcode=7'b0100011, f3=3, rs1=2, rs2=6, imm=16 -> 32'h00613823 at BASE_ADDR+4.
REQ-042 B: fmt=2, opcode=7'b1100011, f3=0, rs1=1, rs2=2, imm=-4 -> 32'hFE208EE3.
REQ-043 I with imm=2048 -> no out_we; err=1, err_code=1; next valid word still goes to the unchanged address.
REQ-044 B with imm=3 -> err_code=2, no write.
REQ-045 MEM_WORDS=4, back-to-back valid -> 4 strobes at +0,+4,+8,+12; full=1, in_ready=0; start -> RUN, address back to BASE_ADDR, err cleared; rst_n low mid-stream -> all outputs at reset values immediately.
